// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and divide-by-zero constants for the sequential ALU.
package alu_pkg;

  localparam int unsigned OPW = 5;

  localparam logic [OPW-1:0] OP_LD     = 5'd0;
  localparam logic [OPW-1:0] OP_LDI    = 5'd1;
  localparam logic [OPW-1:0] OP_ST     = 5'd2;
  localparam logic [OPW-1:0] OP_ADD    = 5'd3;
  localparam logic [OPW-1:0] OP_SUB    = 5'd4;
  localparam logic [OPW-1:0] OP_AND    = 5'd5;
  localparam logic [OPW-1:0] OP_OR     = 5'd6;
  localparam logic [OPW-1:0] OP_ROR    = 5'd7;
  localparam logic [OPW-1:0] OP_ROL    = 5'd8;
  localparam logic [OPW-1:0] OP_SHR    = 5'd9;
  localparam logic [OPW-1:0] OP_SHRA   = 5'd10;
  localparam logic [OPW-1:0] OP_SHL    = 5'd11;
  localparam logic [OPW-1:0] OP_ADDI   = 5'd12;
  localparam logic [OPW-1:0] OP_ANDI   = 5'd13;
  localparam logic [OPW-1:0] OP_ORI    = 5'd14;
  localparam logic [OPW-1:0] OP_MUL    = 5'd15;
  localparam logic [OPW-1:0] OP_DIV    = 5'd16;
  localparam logic [OPW-1:0] OP_NEG    = 5'd17;
  localparam logic [OPW-1:0] OP_NOT    = 5'd18;
  localparam logic [OPW-1:0] OP_BRANCH = 5'd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Divide by zero returns LO filled with this bit and HI = dividend.
  localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative signed engine: radix-2 Booth multiply / restoring divide sharing one WIDTH+1 adder.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   result_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             run, div_mode, q1, qneg, rneg;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc, acc_n, add_a, add_b, sum, shifted;
  logic [WIDTH-1:0] q, q_n, m, a_mag, b_mag, rem, quo;
  logic             q1_n, add_sub;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  // Shared adder: Booth add/sub of M, or trial subtract of the divisor.
  always_comb begin
    shifted = {acc[WIDTH-1:0], q[WIDTH-1]};
    add_a   = div_mode ? shifted : acc;
    add_b   = div_mode ? {1'b0, m} : {m[WIDTH-1], m};
    add_sub = div_mode | (q[0] & ~q1);
    sum     = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
    acc_n   = acc;
    q_n     = q;
    q1_n    = q1;
    if (div_mode) begin
      if (sum[WIDTH]) begin
        acc_n = shifted;
        q_n   = {q[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = sum;
        q_n   = {q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_n = (q[0] ^ q1) ? sum : acc;
      q_n   = {acc_n[0], q[WIDTH-1:1]};
      q1_n  = q[0];
      acc_n = {acc_n[WIDTH], acc_n[WIDTH:1]};
    end
  end

  // Final step result with sign fix-up, consumed by the top on done_c.
  always_comb begin
    rem = acc_n[WIDTH-1:0];
    quo = q_n;
    if (div_mode) result_c = {rneg ? -rem : rem, qneg ? -quo : quo};
    else          result_c = {acc_n[WIDTH-1:0], q_n};
  end

  assign done_c = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      q1       <= 1'b0;
      m        <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
    end else if (start) begin
      run      <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      acc      <= '0;
      q        <= is_div ? a_mag : a;
      q1       <= 1'b0;
      m        <= is_div ? b_mag : b;
      qneg     <= a[WIDTH-1] ^ b[WIDTH-1];
      rneg     <= a[WIDTH-1];
    end else if (run) begin
      acc <= acc_n;
      q   <= q_n;
      q1  <= q1_n;
      cnt <= cnt + CW'(1);
      if (done_c) run <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: handshake FSM, single-cycle ops and registered result/flags around seq_muldiv.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_A,
  input  logic [WIDTH-1:0]     in_B,
  input  logic [OPW-1:0]       op_code,
  input  logic                 bf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 zero,
  output logic                 neg,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int unsigned      SHW   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_t             state;
  logic               accept, b_zero, is_mul, is_div, eng_start, eng_done_c;
  logic [2*WIDTH-1:0] eng_result_c, simple_c;
  logic [WIDTH-1:0]   simple_lo, simple_hi;
  logic [SHW-1:0]     rot_amt;

  assign accept    = in_valid && (state == IDLE);
  assign b_zero    = (in_B == '0);
  assign is_mul    = (op_code == OP_MUL);
  assign is_div    = (op_code == OP_DIV);
  assign eng_start = accept && (is_mul || (is_div && !b_zero));
  assign rot_amt   = SHW'(in_B % W_VAL);

  // Single-cycle results; DIV here is only reached with a zero divisor.
  always_comb begin
    simple_lo = '0;
    simple_hi = '0;
    case (op_code)
      OP_OR, OP_ORI:   simple_lo = in_A | in_B;
      OP_AND, OP_ANDI: simple_lo = in_A & in_B;
      OP_NOT:          simple_lo = ~in_B;
      OP_NEG:          simple_lo = -in_B;
      OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST:
                       simple_lo = in_A + in_B;
      OP_SUB:          simple_lo = in_A - in_B;
      OP_SHL:          simple_lo = (in_B >= W_VAL) ? '0 : (in_A << in_B);
      OP_SHR:          simple_lo = (in_B >= W_VAL) ? '0 : (in_A >> in_B);
      OP_SHRA: begin
        if (in_B >= W_VAL) simple_lo = {WIDTH{in_A[WIDTH-1]}};
        else               simple_lo = $signed(in_A) >>> in_B;
      end
      OP_ROL:          simple_lo = WIDTH'(({in_A, in_A} << rot_amt) >> WIDTH);
      OP_ROR:          simple_lo = WIDTH'({in_A, in_A} >> rot_amt);
      OP_BRANCH:       simple_lo = bf ? (in_A + in_B) : in_A;
      OP_DIV: begin
        simple_lo = {WIDTH{DIV0_LO_FILL}};
        simple_hi = in_A;
      end
      default:         simple_lo = '0;
    endcase
  end

  assign simple_c = {simple_hi, simple_lo};

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start    (eng_start),
    .is_div   (is_div),
    .a        (in_A),
    .b        (in_B),
    .done_c   (eng_done_c),
    .result_c (eng_result_c)
  );

  // Control FSM with all handshake outputs and result flags registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out         <= '0;
      zero        <= 1'b0;
      neg         <= 1'b0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (eng_start) begin
              state <= is_mul ? MUL : DIV;
              busy  <= 1'b1;
            end else begin
              state       <= DONE;
              out_valid   <= 1'b1;
              out         <= simple_c;
              zero        <= (simple_c == '0);
              neg         <= simple_lo[WIDTH-1];
              div_by_zero <= is_div && b_zero;
            end
          end
        end
        MUL, DIV: begin
          if (eng_done_c) begin
            state       <= DONE;
            busy        <= 1'b0;
            out_valid   <= 1'b1;
            out         <= eng_result_c;
            zero        <= (eng_result_c == '0);
            neg         <= (state == MUL) ? eng_result_c[2*WIDTH-1] : eng_result_c[WIDTH-1];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v32, r32, ov32, ordy32, bf32, z32, n32, d32, busy32;
  logic [31:0] a32, b32;
  logic [4:0]  op32;
  logic [63:0] o32;

  logic        v8, r8, ov8, ordy8, bf8, z8, n8, d8, busy8;
  logic [7:0]  a8, b8;
  logic [4:0]  op8;
  logic [15:0] o8;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(32)) u_alu32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_A(a32), .in_B(b32),
    .op_code(op32), .bf(bf32), .out_valid(ov32), .out_ready(ordy32), .out(o32),
    .zero(z32), .neg(n32), .div_by_zero(d32), .busy(busy32)
  );

  seq_alu #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_A(a8), .in_B(b8),
    .op_code(op8), .bf(bf8), .out_valid(ov8), .out_ready(ordy8), .out(o8),
    .zero(z8), .neg(n8), .div_by_zero(d8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: {HI,LO} packed as (HI << w) | LO, from plain signed arithmetic.
  function automatic logic [63:0] ref_alu(input int w, input logic [4:0] op,
                                          input logic [63:0] a, input logic [63:0] b, input bit bf);
    longint sa, sb, p, qt, rm;
    logic [63:0] mask, lo, hi;
    int k;
    mask = (64'd1 << w) - 64'd1;
    sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    k  = int'(b % w);
    lo = 0;
    hi = 0;
    case (op)
      OP_OR, OP_ORI:   lo = a | b;
      OP_AND, OP_ANDI: lo = a & b;
      OP_NOT:          lo = ~b;
      OP_NEG:          lo = 64'd0 - b;
      OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST: lo = a + b;
      OP_SUB:          lo = a - b;
      OP_SHL:          if (b < w) lo = a << b;
      OP_SHR:          if (b < w) lo = a >> b;
      OP_SHRA: begin
        if (b >= w) lo = (sa < 0) ? mask : 64'd0;
        else begin
          p  = sa >>> b;
          lo = p;
        end
      end
      OP_ROL:          lo = (a << k) | (a >> (w - k));
      OP_ROR:          lo = (a >> k) | (a << (w - k));
      OP_BRANCH:       lo = bf ? a + b : a;
      OP_MUL: begin
        p  = sa * sb;
        lo = p;
        p  = p >>> w;
        hi = p;
      end
      OP_DIV: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else begin
          qt = sa / sb;
          rm = sa % sb;
          lo = qt;
          hi = rm;
        end
      end
      default: lo = 0;
    endcase
    lo &= mask;
    hi &= mask;
    return (hi << w) | lo;
  endfunction

  function automatic logic [63:0] cur_out(input int w);
    return (w == 32) ? o32 : {48'd0, o8};
  endfunction
  function automatic logic cur_ov(input int w);
    return (w == 32) ? ov32 : ov8;
  endfunction
  function automatic logic cur_rdy(input int w);
    return (w == 32) ? r32 : r8;
  endfunction
  function automatic logic [3:0] cur_flags(input int w);
    return (w == 32) ? {z32, n32, d32, busy32} : {z8, n8, d8, busy8};
  endfunction

  task automatic drive(input int w, input logic v, input logic [4:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic bf);
    if (w == 32) begin
      v32 = v; op32 = op; a32 = a[31:0]; b32 = b[31:0]; bf32 = bf;
    end else begin
      v8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; bf8 = bf;
    end
  endtask

  task automatic set_ordy(input int w, input logic r);
    if (w == 32) ordy32 = r;
    else         ordy8  = r;
  endtask

  // One transaction: accept, wait (bounded) for the result, check, optional backpressure, drain.
  task automatic issue(input int w, input logic [4:0] op, input logic [63:0] a_in,
                       input logic [63:0] b_in, input bit bf, input int hold,
                       input bit has_want, input logic [63:0] want);
    logic [63:0] mask, a, b, exp, held;
    int lat, exp_lat;
    bit exp_neg, exp_dbz;
    mask    = (64'd1 << w) - 64'd1;
    a       = a_in & mask;
    b       = b_in & mask;
    exp     = ref_alu(w, op, a, b, bf);
    exp_lat = (op == OP_MUL || (op == OP_DIV && b != 0)) ? w + 1 : 1;
    exp_neg = (op == OP_MUL) ? exp[2*w-1] : exp[w-1];
    exp_dbz = (op == OP_DIV) && (b == 0);
    @(negedge clk);
    check("in_ready_idle", 64'(cur_rdy(w)), 64'd1);
    set_ordy(w, hold == 0);
    drive(w, 1'b1, op, a, b, bf);
    @(posedge clk);
    #1;
    drive(w, 1'b0, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    check("busy_after_accept", 64'(cur_flags(w) & 4'b0001), 64'(exp_lat > 1));
    lat = 1;
    while (!cur_ov(w) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("out", cur_out(w), exp);
    if (has_want) check("out_const", cur_out(w), want);
    check("flags_zndb", 64'(cur_flags(w)), 64'({exp == 0, exp_neg, exp_dbz, 1'b0}));
    check("in_ready_done", 64'(cur_rdy(w)), 64'd0);
    held = cur_out(w);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      drive(w, 1'b1, OP_ADD, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
      @(posedge clk);
      #1;
      check("bp_out_stable", cur_out(w), held);
      check("bp_valid_ready", 64'({cur_ov(w), cur_rdy(w)}), 64'b10);
    end
    @(negedge clk);
    drive(w, 1'b0, OP_ADD, 64'd0, 64'd0, 1'b0);
    set_ordy(w, 1'b1);
    @(posedge clk);
    #1;
    check("drain_valid_ready", 64'({cur_ov(w), cur_rdy(w)}), 64'b01);
  endtask

  function automatic logic [63:0] rand_operand(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom % 8)
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  function automatic logic [4:0] rand_op();
    int r;
    r = $urandom_range(0, 27);
    if (r >= 24) return (r % 2 == 1) ? OP_MUL : OP_DIV;
    return 5'(r);
  endfunction

  initial begin
    rst = 1'b1;
    drive(32, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    drive(8, 1'b0, 5'd0, 64'd0, 64'd0, 1'b0);
    ordy32 = 1'b1;
    ordy8  = 1'b1;
    repeat (2) @(negedge clk);
    check("reset32", {o32[31:0], 28'd0, ov32, r32, busy32, z32}, {32'd0, 28'd0, 4'b0100});
    check("reset8", {o8, 44'd0, ov8, r8, d8, n8}, {16'd0, 44'd0, 4'b0100});
    rst = 1'b0;

    issue(32, OP_ADD, 64'd7, 64'hFFFF_FFFD, 1'b0, 0, 1'b1, 64'h4);
    issue(32, OP_MUL, 64'hFFFF_FFFA, 64'd7, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);
    issue(32, OP_DIV, 64'hFFFF_FFF9, 64'd2, 1'b0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(32, OP_DIV, 64'd5, 64'd0, 1'b0, 0, 1'b1, 64'h0000_0005_FFFF_FFFF);
    issue(32, OP_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 0, 1'b1, 64'h0000_0000_8000_0000);
    issue(32, OP_SHRA, 64'h8000_0000, 64'd40, 1'b0, 0, 1'b1, 64'h0000_0000_FFFF_FFFF);
    issue(32, OP_ROL, 64'h8000_0001, 64'd33, 1'b0, 0, 1'b1, 64'h3);
    issue(32, OP_SHL, 64'h1, 64'd32, 1'b0, 0, 1'b1, 64'h0);
    issue(32, OP_BRANCH, 64'd100, 64'd20, 1'b1, 0, 1'b1, 64'd120);
    issue(32, 5'd25, 64'd9, 64'd9, 1'b0, 0, 1'b1, 64'h0);
    issue(32, OP_MUL, 64'h8000_0000, 64'h8000_0000, 1'b0, 5, 1'b1, 64'h4000_0000_0000_0000);
    issue(32, OP_SUB, 64'd3, 64'd3, 1'b0, 5, 1'b1, 64'h0);

    // Reset in the middle of a multiply, then a fresh ADD.
    @(negedge clk);
    drive(32, 1'b1, OP_MUL, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0);
    @(posedge clk);
    #1;
    drive(32, 1'b0, OP_ADD, 64'd0, 64'd0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_mul", {o32, 28'd0, ov32, r32, busy32, d32}, {64'd0, 28'd0, 4'b0100});
    @(negedge clk);
    rst = 1'b0;
    issue(32, OP_ADD, 64'd100, 64'd23, 1'b0, 0, 1'b1, 64'd123);

    issue(8, OP_MUL, 64'hFA, 64'h07, 1'b0, 0, 1'b1, 64'hFFD6);
    issue(8, OP_DIV, 64'hF9, 64'h02, 1'b0, 0, 1'b1, 64'hFFFD);
    issue(8, OP_DIV, 64'h05, 64'h00, 1'b0, 0, 1'b1, 64'h05FF);
    issue(8, OP_DIV, 64'h80, 64'hFF, 1'b0, 0, 1'b1, 64'h0080);

    for (int i = 0; i < 300; i++)
      issue(32, rand_op(), rand_operand(32), rand_operand(32), 1'($urandom),
            ($urandom % 16 == 0) ? 2 : 0, 1'b0, 64'd0);
    for (int i = 0; i < 10000; i++)
      issue(8, rand_op(), rand_operand(8), rand_operand(8), 1'($urandom),
            ($urandom % 64 == 0) ? 1 : 0, 1'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
